// File: rtl/io_peer_pkg.sv
// rtl/io_peer_pkg.sv - shared defaults, pointer sizing and FIFO status type for the IO port peer
package io_peer_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  // Wide enough to carry the occupancy of any practical FIFO depth (up to 255).
  localparam int STAT_CNT_W = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic                  full;
    logic                  empty;
    logic [STAT_CNT_W-1:0] count;
  } fifo_status_t;

endpackage

// File: rtl/io_peer_fifo.sv
// rtl/io_peer_fifo.sv - single-clock FIFO with gated head output; push/pop arrive pre-qualified
module io_peer_fifo
  import io_peer_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head_data,
  output fifo_status_t      status
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; the gated head hides stale words.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty        = (count_q == '0);
  assign head_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign status.full  = (count_q == CNT_W'(DEPTH));
  assign status.empty = empty;
  assign status.count = STAT_CNT_W'(count_q);

endmodule

// File: rtl/io_port_peer.sv
// rtl/io_port_peer.sv - IO port peer: OUT writes to host TX FIFO, host words to IN via RX FIFO
// Optional loopback routing of OUT writes into the RX FIFO when IO_PEER_LOOPBACK_EN is defined.
module io_port_peer
  import io_peer_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] port_out,
  input  logic              port_out_wr,
  output logic [WORD_W-1:0] port_in,
  input  logic              port_in_rd,
  output logic              port_in_valid,
  output logic [WORD_W-1:0] host_tx_data,
  output logic              host_tx_valid,
  input  logic              host_tx_ready,
  input  logic [WORD_W-1:0] host_rx_data,
  input  logic              host_rx_valid,
  output logic              host_rx_ready,
  output logic              tx_ovf,
  output logic              rx_udf
`ifdef IO_PEER_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  fifo_status_t      tx_st, rx_st;
  logic              lb_en;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic [WORD_W-1:0] rx_push_data;
  logic              tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;

`ifdef IO_PEER_LOOPBACK_EN
  assign lb_en = loopback;
`else
  assign lb_en = 1'b0;
`endif

  assign host_tx_valid = |tx_st.count;
  assign port_in_valid = |rx_st.count;
  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
  assign host_rx_ready = !rx_st.full && !lb_en;

  assign tx_push      = port_out_wr && !lb_en && !tx_st.full;
  assign tx_pop       = host_tx_valid && host_tx_ready;
  assign rx_push      = lb_en ? (port_out_wr && !rx_st.full) : (host_rx_valid && host_rx_ready);
  assign rx_push_data = lb_en ? port_out : host_rx_data;
  assign rx_pop       = port_in_rd && port_in_valid;

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (port_out_wr && (lb_en ? rx_st.full : tx_st.full)) tx_ovf_d = 1'b1;
    if (port_in_rd && rx_st.empty)                         rx_udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  assign tx_ovf = tx_ovf_q;
  assign rx_udf = rx_udf_q;

  io_peer_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (port_out),
    .pop       (tx_pop),
    .head_data (host_tx_data),
    .status    (tx_st)
  );

  io_peer_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .head_data (port_in),
    .status    (rx_st)
  );

endmodule

// File: tb/tb_io_port_peer.sv
// tb/tb_io_port_peer.sv - directed self-checking bench for io_port_peer
module tb_io_port_peer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] port_out;
  logic        port_out_wr;
  logic [15:0] port_in;
  logic        port_in_rd;
  logic        port_in_valid;
  logic [15:0] host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic [15:0] host_rx_data;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic        tx_ovf;
  logic        rx_udf;
`ifdef IO_PEER_LOOPBACK_EN
  logic        loopback;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_port_peer dut (
    .clk           (clk),
    .reset         (reset),
    .port_out      (port_out),
    .port_out_wr   (port_out_wr),
    .port_in       (port_in),
    .port_in_rd    (port_in_rd),
    .port_in_valid (port_in_valid),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .tx_ovf        (tx_ovf),
    .rx_udf        (rx_udf)
`ifdef IO_PEER_LOOPBACK_EN
    ,
    .loopback      (loopback)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic out_wr(input logic [15:0] w);
    port_out = w;
    port_out_wr = 1'b1;
    @(negedge clk);
    port_out_wr = 1'b0;
  endtask

  task automatic host_push(input logic [15:0] w);
    host_rx_data = w;
    host_rx_valid = 1'b1;
    @(negedge clk);
    host_rx_valid = 1'b0;
  endtask

  task automatic in_rd();
    port_in_rd = 1'b1;
    @(negedge clk);
    port_in_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    port_out = '0; port_out_wr = 1'b0; port_in_rd = 1'b0;
    host_tx_ready = 1'b0; host_rx_data = '0; host_rx_valid = 1'b0;
`ifdef IO_PEER_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_tx_valid", 32'(host_tx_valid), 32'd0);
    check("rst_tx_data", 32'(host_tx_data), 32'd0);
    check("rst_rx_ready", 32'(host_rx_ready), 32'd1);
    check("rst_in_valid", 32'(port_in_valid), 32'd0);
    check("rst_port_in", 32'(port_in), 32'd0);
    check("rst_flags", {30'd0, tx_ovf, rx_udf}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two OUT words held, then released to the host in order
    out_wr(16'h1111);
    check("t2_head_after_wr", 32'(host_tx_data), 32'h1111);
    check("t2_valid_after_wr", 32'(host_tx_valid), 32'd1);
    out_wr(16'h2222);
    check("t2_held", 32'(host_tx_data), 32'h1111);
    host_tx_ready = 1'b1;
    @(negedge clk);
    check("t2_second", 32'(host_tx_data), 32'h2222);
    @(negedge clk);
    check("t2_valid_drop", 32'(host_tx_valid), 32'd0);
    check("t2_data_zero", 32'(host_tx_data), 32'd0);
    host_tx_ready = 1'b0;

    // Overflow: fifth write dropped
    for (int i = 1; i <= 5; i++) out_wr(16'(i));
    check("t3_ovf", 32'(tx_ovf), 32'd1);
    host_tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain", 32'(host_tx_data), 32'(i));
      @(negedge clk);
    end
    check("t3_empty", 32'(host_tx_valid), 32'd0);
    host_tx_ready = 1'b0;

    // Asynchronous reset mid-traffic
    for (int i = 0; i < 3; i++) out_wr(16'h0C00 + 16'(i));
    check("t1_pre_valid", 32'(host_tx_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t1_tx_valid", 32'(host_tx_valid), 32'd0);
    check("t1_rx_ready", 32'(host_rx_ready), 32'd1);
    check("t1_flags", {30'd0, tx_ovf, rx_udf}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t1_post_valid", 32'(host_tx_valid), 32'd0);

    // Host word served on port_in, consumed by IN
    host_push(16'hABCD);
    check("t4_valid", 32'(port_in_valid), 32'd1);
    check("t4_data", 32'(port_in), 32'hABCD);
    in_rd();
    check("t4_data_zero", 32'(port_in), 32'd0);
    check("t4_valid_zero", 32'(port_in_valid), 32'd0);
    check("t4_no_udf", 32'(rx_udf), 32'd0);

    // Underflow with a same-cycle host push
    port_in_rd = 1'b1;
    host_push(16'h0042);
    port_in_rd = 1'b0;
    check("t5_udf", 32'(rx_udf), 32'd1);
    check("t5_data", 32'(port_in), 32'h0042);
    check("t5_valid", 32'(port_in_valid), 32'd1);
    in_rd();
    check("t5_empty", 32'(port_in_valid), 32'd0);
    check("t5_udf_sticky", 32'(rx_udf), 32'd1);

    // RX full: ready drops, extra host word refused
    for (int i = 0; i < 4; i++) host_push(16'h0B00 + 16'(i));
    check("rxf_ready", 32'(host_rx_ready), 32'd0);
    host_push(16'h0BFF);
    for (int i = 0; i < 4; i++) begin
      check("rxf_drain", 32'(port_in), 32'h0B00 + 32'(i));
      in_rd();
    end
    check("rxf_empty", 32'(port_in_valid), 32'd0);
    check("rxf_ready_back", 32'(host_rx_ready), 32'd1);

    // TX wrap with simultaneous push and pop each cycle
    out_wr(16'h0200);
    for (int i = 1; i <= 10; i++) begin
      check("t6_tx_wrap", 32'(host_tx_data), 32'h0200 + 32'(i - 1));
      host_tx_ready = 1'b1;
      out_wr(16'h0200 + 16'(i));
      host_tx_ready = 1'b0;
    end
    check("t6_tx_last", 32'(host_tx_data), 32'h020A);
    host_tx_ready = 1'b1;
    @(negedge clk);
    host_tx_ready = 1'b0;
    check("t6_tx_empty", 32'(host_tx_valid), 32'd0);

    // RX wrap through ten push/pop pairs
    for (int i = 0; i < 10; i++) begin
      host_push(16'h0300 + 16'(i));
      check("t6_rx_wrap", 32'(port_in), 32'h0300 + 32'(i));
      in_rd();
    end
    check("t6_rx_empty", 32'(port_in_valid), 32'd0);

    // Full TX: same-cycle pop does not admit the push
    check("fp_ovf_clear", 32'(tx_ovf), 32'd0);
    for (int i = 0; i < 4; i++) out_wr(16'h0A00 + 16'(i));
    host_tx_ready = 1'b1;
    out_wr(16'h0A04);
    check("fp_ovf", 32'(tx_ovf), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      check("fp_drain", 32'(host_tx_data), 32'h0A00 + 32'(i));
      @(negedge clk);
    end
    check("fp_empty", 32'(host_tx_valid), 32'd0);
    host_tx_ready = 1'b0;

`ifdef IO_PEER_LOOPBACK_EN
    loopback = 1'b1;
    #1;
    check("lb_rx_ready", 32'(host_rx_ready), 32'd0);
    out_wr(16'h5A5A);
    check("lb_port_in", 32'(port_in), 32'h5A5A);
    check("lb_tx_idle", 32'(host_tx_valid), 32'd0);
    in_rd();
    check("lb_rx_empty", 32'(port_in_valid), 32'd0);
    loopback = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
